// File: rtl/ex_muldiv.sv
// Iterative RV32M multiply/divide unit beside the EX-stage ALU: one shift-add or
// restoring-subtract step per cycle, with one-cycle short cuts for divide-by-zero and overflow.
module ex_muldiv #(
  parameter int WIDTH = 32
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_valid,
  input  logic [2:0]       i_funct3,
  input  logic [WIDTH-1:0] i_A,
  input  logic [WIDTH-1:0] i_B,
  input  logic             i_flush,
  output logic             o_busy,
  output logic             o_valid,
  output logic [WIDTH-1:0] o_result
);
  localparam int CW = $clog2(WIDTH) + 1;

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  state_t               state_q;
  logic [CW-1:0]        cnt_q;
  logic [2:0]           funct3_q;
  logic                 neg_q;
  logic [2*WIDTH-1:0]   acc_q;
  logic [2*WIDTH-1:0]   acc_d;
  logic [WIDTH-1:0]     opnd_q;
  logic                 valid_q;
  logic [WIDTH-1:0]     result_q;

  logic                 sgn_a, sgn_b, conv_a, conv_b, neg_d;
  logic                 is_div, div_zero, div_ovf, special;
  logic [WIDTH-1:0]     mag_a, mag_b, special_res;

  // acc holds {partial product, multiplier} for multiply and {remainder, dividend/quotient} for divide.
  function automatic logic [2*WIDTH-1:0] mul_step(input logic [2*WIDTH-1:0] acc,
                                                   input logic [WIDTH-1:0]   mcand);
    logic [WIDTH:0] sum;
    sum = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, mcand} : {(WIDTH+1){1'b0}});
    return {sum, acc[WIDTH-1:1]};
  endfunction

  function automatic logic [2*WIDTH-1:0] div_step(input logic [2*WIDTH-1:0] acc,
                                                   input logic [WIDTH-1:0]   dvsr);
    logic [WIDTH:0]     shifted;
    logic [WIDTH:0]     diff;
    logic [2*WIDTH-1:0] nxt;
    shifted = {acc[2*WIDTH-1:WIDTH], acc[WIDTH-1]};
    diff    = shifted - {1'b0, dvsr};
    if (diff[WIDTH]) nxt = {shifted[WIDTH-1:0], acc[WIDTH-2:0], 1'b0};
    else             nxt = {diff[WIDTH-1:0], acc[WIDTH-2:0], 1'b1};
    return nxt;
  endfunction

  function automatic logic [WIDTH-1:0] finalize(input logic [2*WIDTH-1:0] acc,
                                                input logic [2:0]         f3,
                                                input logic               neg);
    logic [2*WIDTH-1:0] prod;
    logic [WIDTH-1:0]   res;
    prod = neg ? -acc : acc;
    case (f3)
      3'b000:                 res = acc[WIDTH-1:0];
      3'b001, 3'b010, 3'b011: res = prod[2*WIDTH-1:WIDTH];
      3'b100, 3'b101:         res = neg ? -acc[WIDTH-1:0] : acc[WIDTH-1:0];
      default:                res = neg ? -acc[2*WIDTH-1:WIDTH] : acc[2*WIDTH-1:WIDTH];
    endcase
    return res;
  endfunction

  always_comb begin
    is_div = i_funct3[2];
    sgn_a  = i_A[WIDTH-1];
    sgn_b  = i_B[WIDTH-1];
    conv_a = (i_funct3 == 3'b001) | (i_funct3 == 3'b010) |
             (i_funct3 == 3'b100) | (i_funct3 == 3'b110);
    conv_b = (i_funct3 == 3'b001) | (i_funct3 == 3'b100) | (i_funct3 == 3'b110);
    mag_a  = (conv_a & sgn_a) ? -i_A : i_A;
    mag_b  = (conv_b & sgn_b) ? -i_B : i_B;
    case (i_funct3)
      3'b001, 3'b100: neg_d = sgn_a ^ sgn_b;
      3'b010, 3'b110: neg_d = sgn_a;
      default:        neg_d = 1'b0;
    endcase
    div_zero = is_div & (i_B == '0);
    div_ovf  = is_div & ~i_funct3[0] & (i_A == {1'b1, {(WIDTH-1){1'b0}}}) & (&i_B);
    special  = div_zero | div_ovf;
    // Overflow: DIV returns the dividend (most negative value), REM returns zero.
    if (div_zero) special_res = i_funct3[1] ? i_A : '1;
    else          special_res = i_funct3[1] ? '0 : i_A;
  end

  assign acc_d    = funct3_q[2] ? div_step(acc_q, opnd_q) : mul_step(acc_q, opnd_q);
  assign o_busy   = ~i_rst & ((state_q == CALC) | ((state_q == IDLE) & i_valid & ~i_flush));
  assign o_valid  = valid_q;
  assign o_result = result_q;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      funct3_q <= '0;
      neg_q    <= 1'b0;
      acc_q    <= '0;
      opnd_q   <= '0;
      valid_q  <= 1'b0;
      result_q <= '0;
    end else begin
      valid_q  <= 1'b0;
      result_q <= '0;
      case (state_q)
        IDLE: begin
          if (i_valid && !i_flush) begin
            funct3_q <= i_funct3;
            neg_q    <= neg_d;
            cnt_q    <= '0;
            if (special) begin
              state_q  <= DONE;
              valid_q  <= 1'b1;
              result_q <= special_res;
            end else begin
              state_q <= CALC;
              acc_q   <= {{WIDTH{1'b0}}, (is_div ? mag_a : mag_b)};
              opnd_q  <= is_div ? mag_b : mag_a;
            end
          end
        end
        CALC: begin
          if (i_flush) begin
            state_q <= IDLE;
          end else begin
            acc_q <= acc_d;
            cnt_q <= cnt_q + 1'b1;
            if (cnt_q == CW'(WIDTH - 1)) begin
              state_q  <= DONE;
              valid_q  <= 1'b1;
              result_q <= finalize(acc_d, funct3_q, neg_q);
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ex_muldiv.sv
// Bench for ex_muldiv: vector table through a result scoreboard, plus flush and reset sequences.
module tb_ex_muldiv;
  localparam int W   = 32;
  localparam int NRM = W + 1;
  localparam int SPC = 1;

  logic         clk = 1'b0;
  logic         rst, valid, flush;
  logic [2:0]   f3;
  logic [W-1:0] a, b;
  logic         busy, ovalid;
  logic [W-1:0] res;

  int checks = 0;
  int errors = 0;
  logic [W-1:0] sb[$];
  logic [W-1:0] exp_v;

  typedef struct {
    logic [2:0]   f3;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] exp;
    int           vcyc;
    bit           chain;
  } vec_t;

  vec_t vecs[$];

  always #5 clk = ~clk;

  ex_muldiv #(.WIDTH(W)) dut (
    .i_clk    (clk),
    .i_rst    (rst),
    .i_valid  (valid),
    .i_funct3 (f3),
    .i_A      (a),
    .i_B      (b),
    .i_flush  (flush),
    .o_busy   (busy),
    .o_valid  (ovalid),
    .o_result (res)
  );

  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s: got %h, expected %h", name, act, expv);
    end
  endtask

  // Scoreboard: every o_valid pulse consumes one expected result.
  always @(negedge clk) begin
    if (!rst) begin
      if (ovalid) begin
        if (sb.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_valid: got result %h, expected no pulse", res);
        end else begin
          exp_v = sb.pop_front();
          check("result", res, exp_v);
        end
      end else if (res !== '0) begin
        checks++;
        errors++;
        $display("FAIL result_not_zero: got %h while o_valid low, expected 0", res);
      end
    end
  end

  task automatic run_op(input vec_t v, input vec_t nxt, input string tag);
    int n;
    int busy_cnt;
    bit seen;
    valid = 1'b1; f3 = v.f3; a = v.a; b = v.b;
    sb.push_back(v.exp);
    @(negedge clk);
    busy_cnt = busy ? 1 : 0;
    @(posedge clk); #1 valid = 1'b0;
    n = 0; seen = 1'b0;
    while (!seen && n < W + 4) begin
      @(negedge clk);
      n++;
      if (ovalid) seen = 1'b1;
      else if (busy) busy_cnt++;
    end
    check({tag, " valid_cycle"}, W'(n), W'(v.vcyc));
    check({tag, " busy_cycles"}, W'(busy_cnt), W'(v.vcyc));
    check({tag, " busy_in_done"}, {31'b0, busy}, '0);
    if (v.chain) begin
      valid = 1'b1; f3 = nxt.f3; a = nxt.a; b = nxt.b;
    end
    @(posedge clk); #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected simulation end");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t nxt;
    vec_t v;
    int n;
    vecs.push_back('{3'b000, 32'h00000007, 32'hFFFFFFFD, 32'hFFFFFFEB, NRM, 1'b0});
    vecs.push_back('{3'b001, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000000, NRM, 1'b0});
    vecs.push_back('{3'b010, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, NRM, 1'b0});
    vecs.push_back('{3'b011, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, NRM, 1'b0});
    vecs.push_back('{3'b001, 32'h80000000, 32'h80000000, 32'h40000000, NRM, 1'b0});
    vecs.push_back('{3'b010, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, NRM, 1'b0});
    vecs.push_back('{3'b011, 32'h80000000, 32'h00000002, 32'h00000001, NRM, 1'b0});
    vecs.push_back('{3'b000, 32'h12345678, 32'h00000010, 32'h23456780, NRM, 1'b0});
    vecs.push_back('{3'b100, 32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFD, NRM, 1'b1});
    vecs.push_back('{3'b110, 32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFF, NRM, 1'b0});
    vecs.push_back('{3'b100, 32'h00000007, 32'hFFFFFFFE, 32'hFFFFFFFD, NRM, 1'b1});
    vecs.push_back('{3'b110, 32'h00000007, 32'hFFFFFFFE, 32'h00000001, NRM, 1'b0});
    vecs.push_back('{3'b100, 32'h00000003, 32'hFFFFFFFB, 32'h00000000, NRM, 1'b0});
    vecs.push_back('{3'b110, 32'hFFFFFFFD, 32'h00000005, 32'hFFFFFFFD, NRM, 1'b0});
    vecs.push_back('{3'b101, 32'hFFFFFFFF, 32'h00000001, 32'hFFFFFFFF, NRM, 1'b0});
    vecs.push_back('{3'b111, 32'hFFFFFFFF, 32'h00000010, 32'h0000000F, NRM, 1'b0});
    vecs.push_back('{3'b100, 32'h80000000, 32'h00000002, 32'hC0000000, NRM, 1'b0});
    vecs.push_back('{3'b101, 32'h00000005, 32'h00000000, 32'hFFFFFFFF, SPC, 1'b0});
    vecs.push_back('{3'b110, 32'h00000005, 32'h00000000, 32'h00000005, SPC, 1'b0});
    vecs.push_back('{3'b100, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, SPC, 1'b0});
    vecs.push_back('{3'b110, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, SPC, 1'b0});
    vecs.push_back('{3'b100, 32'h80000000, 32'h00000000, 32'hFFFFFFFF, SPC, 1'b0});
    vecs.push_back('{3'b101, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, NRM, 1'b0});
    vecs.push_back('{3'b111, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, NRM, 1'b0});

    rst = 1'b1; valid = 1'b0; flush = 1'b0; f3 = '0; a = '0; b = '0;
    #12;
    check("reset_busy", {31'b0, busy}, '0);
    check("reset_valid", {31'b0, ovalid}, '0);
    check("reset_result", res, '0);
    @(negedge clk) rst = 1'b0;
    @(posedge clk); #1;

    for (int i = 0; i < vecs.size(); i++) begin
      nxt = (i + 1 < vecs.size()) ? vecs[i+1] : vecs[i];
      run_op(vecs[i], nxt, $sformatf("vec%0d", i));
    end

    // Flush wins over accept in IDLE.
    valid = 1'b1; flush = 1'b1; f3 = 3'b000; a = 32'd3; b = 32'd4;
    @(negedge clk);
    check("flush_idle_busy", {31'b0, busy}, '0);
    @(posedge clk); #1 valid = 1'b0; flush = 1'b0;
    @(negedge clk);
    check("flush_idle_not_accepted", {31'b0, busy}, '0);
    @(posedge clk); #1;

    // Flush after 10 iterations; the aborted MUL must never produce a pulse.
    valid = 1'b1; f3 = 3'b000; a = 32'd5; b = 32'd6;
    @(posedge clk); #1 valid = 1'b0;
    repeat (10) @(posedge clk);
    #1 flush = 1'b1;
    @(negedge clk);
    check("flush_calc_busy_before", {31'b0, busy}, 32'd1);
    @(posedge clk); #1 flush = 1'b0;
    @(negedge clk);
    check("flush_calc_busy_after", {31'b0, busy}, '0);
    check("flush_calc_valid_after", {31'b0, ovalid}, '0);
    repeat (W + 4) @(negedge clk);
    @(posedge clk); #1;
    v = '{3'b000, 32'd3, 32'd4, 32'd12, NRM, 1'b0};
    run_op(v, v, "mul_after_flush");

    // Asynchronous reset while the result is being presented.
    valid = 1'b1; f3 = 3'b000; a = 32'd7; b = 32'd3;
    sb.push_back(32'd21);
    @(posedge clk); #1 valid = 1'b0;
    n = 0;
    while (!ovalid && n < W + 4) begin
      @(negedge clk);
      n++;
    end
    check("rst_done_reached", W'(n), W'(NRM));
    #2 rst = 1'b1;
    #1;
    check("rst_async_valid", {31'b0, ovalid}, '0);
    check("rst_async_result", res, '0);
    @(negedge clk) rst = 1'b0;
    @(posedge clk); #1;

    // Asynchronous reset mid-CALC.
    valid = 1'b1; f3 = 3'b101; a = 32'd100; b = 32'd7;
    @(posedge clk); #1 valid = 1'b0;
    repeat (5) @(posedge clk);
    #3;
    check("calc_busy_before_rst", {31'b0, busy}, 32'd1);
    rst = 1'b1;
    #1;
    check("rst_mid_busy", {31'b0, busy}, '0);
    check("rst_mid_valid", {31'b0, ovalid}, '0);
    check("rst_mid_result", res, '0);
    @(negedge clk) rst = 1'b0;
    @(posedge clk); #1;
    v = '{3'b101, 32'd100, 32'd7, 32'd14, NRM, 1'b0};
    run_op(v, v, "divu_after_rst");
    v = '{3'b111, 32'd100, 32'd7, 32'd2, NRM, 1'b0};
    run_op(v, v, "remu_after_rst");

    repeat (3) @(posedge clk);
    check("scoreboard_empty", W'(sb.size()), '0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
